// File: rtl/routing_cfg_pkg.sv
// Shared types and helpers for the routing configuration loader.
// CHECK exists only when ROUTING_CFG_CRC_EN is defined.
package routing_cfg_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      COMMIT
`ifdef ROUTING_CFG_CRC_EN
      , CHECK
`endif
   } state_t;

   localparam logic [7:0] CRC8_POLY = 8'h07;

   // Bytes needed to carry wire_width*12 select bits, rounded up.
   function automatic int nbytes(input int wireWidth);
      return (wireWidth * 12 + 7) / 8;
   endfunction

endpackage

// File: rtl/routing_cfg_crc8.sv
// Combinational byte-wise CRC-8 next-value step (MSB-first).
// Used by routing_config_loader only when ROUTING_CFG_CRC_EN is defined.
module routing_cfg_crc8
   import routing_cfg_pkg::*;
(
   input  logic [7:0] i_crc,
   input  logic [7:0] i_data,
   output logic [7:0] o_crc
);

   always_comb begin
      logic [7:0] w_c;
      w_c = i_crc ^ i_data;
      for (int i = 0; i < 8; i++) begin
         w_c = w_c[7] ? ((w_c << 1) ^ CRC8_POLY) : (w_c << 1);
      end
      o_crc = w_c;
   end

endmodule

// File: rtl/routing_config_loader.sv
// Byte-serial loader that shadows a routing switch configuration and commits it to select.
// Optional frame CRC-8 checking is enabled by defining ROUTING_CFG_CRC_EN.
module routing_config_loader
   import routing_cfg_pkg::*;
#(
   parameter int wire_width = 3
)
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [7:0]                 cfg_data,
   input  logic                       cfg_valid,
   output logic                       cfg_ready,
   input  logic                       cfg_abort,
   output logic [wire_width*12-1:0]   select,
   output logic                       cfg_done,
   output logic                       cfg_err
);

   localparam int SELW   = wire_width * 12;
   localparam int NBYTES = nbytes(wire_width);
   localparam int CNTW   = $clog2(NBYTES + 1);
   localparam logic [CNTW-1:0] LAST = CNTW'(NBYTES - 1);

   state_t            r_state;
   logic [CNTW-1:0]   r_count;
   logic [SELW-1:0]   r_shadow;
   logic [SELW-1:0]   r_select;
   logic              r_done;
   logic [SELW-1:0]   w_shadowNext;
   logic              w_xfer;
   logic              w_load;

   assign cfg_ready = rst_n && (r_state != COMMIT);
   assign w_xfer    = cfg_valid && cfg_ready;
   assign w_load    = w_xfer && !cfg_abort && ((r_state == IDLE) || (r_state == SHIFT));
   assign select    = r_select;
   assign cfg_done  = r_done;

   // One lane per byte; the last lane keeps only the bits that fit in select.
   for (genvar k = 0; k < NBYTES; k++) begin : g_lane
      localparam int LO    = 8 * k;
      localparam int WIDTH = ((SELW - LO) < 8) ? (SELW - LO) : 8;
      assign w_shadowNext[LO +: WIDTH] = (w_load && (r_count == CNTW'(k)))
                                         ? cfg_data[WIDTH-1:0]
                                         : r_shadow[LO +: WIDTH];
   end

`ifdef ROUTING_CFG_CRC_EN
   logic [7:0] r_crc;
   logic [7:0] w_crcNext;
   logic       r_err;

   routing_cfg_crc8 u_crc8 (
      .i_crc  (r_crc),
      .i_data (cfg_data),
      .o_crc  (w_crcNext)
   );

   assign cfg_err = r_err;
`else
   assign cfg_err = 1'b0;
`endif

   // COMMIT ignores abort; elsewhere abort beats a coincident transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_count  <= '0;
         r_shadow <= '0;
         r_select <= '0;
         r_done   <= 1'b0;
`ifdef ROUTING_CFG_CRC_EN
         r_crc    <= '0;
         r_err    <= 1'b0;
`endif
      end else begin
         r_done   <= 1'b0;
         r_shadow <= w_shadowNext;
`ifdef ROUTING_CFG_CRC_EN
         r_err    <= 1'b0;
`endif
         if (r_state == COMMIT) begin
            r_select <= r_shadow;
            r_done   <= 1'b1;
            r_state  <= IDLE;
            r_count  <= '0;
         end else if (cfg_abort) begin
            r_state  <= IDLE;
            r_count  <= '0;
`ifdef ROUTING_CFG_CRC_EN
            r_crc    <= '0;
`endif
         end else if (w_xfer) begin
`ifdef ROUTING_CFG_CRC_EN
            if (r_state == CHECK) begin
               if (cfg_data == r_crc) begin
                  r_state <= COMMIT;
               end else begin
                  r_err   <= 1'b1;
                  r_state <= IDLE;
               end
               r_count <= '0;
               r_crc   <= '0;
            end else
`endif
            begin
               r_count <= r_count + 1'b1;
`ifdef ROUTING_CFG_CRC_EN
               r_crc   <= w_crcNext;
`endif
               if (r_count == LAST) begin
`ifdef ROUTING_CFG_CRC_EN
                  r_state <= CHECK;
`else
                  r_state <= COMMIT;
`endif
               end else begin
                  r_state <= SHIFT;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_routing_config_loader.sv
// Self-checking bench for routing_config_loader at wire_width = 3 (5 data bytes).
// Commits are scoreboarded; define ROUTING_CFG_CRC_EN to exercise the CRC frame format.
module tb_routing_config_loader;

   logic        clk;
   logic        rst_n;
   logic [7:0]  cfg_data;
   logic        cfg_valid;
   logic        cfg_ready;
   logic        cfg_abort;
   logic [35:0] select;
   logic        cfg_done;
   logic        cfg_err;

   int checks = 0;
   int errors = 0;
   int doneCount = 0;
   logic [35:0] expQ[$];

   typedef struct {
      logic [39:0] frame;
      logic [35:0] expSel;
   } vec_t;

   vec_t vecs[4];

   routing_config_loader #(.wire_width(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_data  (cfg_data),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_abort (cfg_abort),
      .select    (select),
      .cfg_done  (cfg_done),
      .cfg_err   (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference CRC-8, poly 0x07, init 0, MSB-first, over bytes 0..4 of the frame.
   function automatic logic [7:0] refCrc(input logic [39:0] f);
      logic [7:0] c;
      c = 8'h00;
      for (int k = 0; k < 5; k++) begin
         c = c ^ f[8*k +: 8];
         for (int b = 0; b < 8; b++) begin
            if (c[7]) c = (c << 1) ^ 8'h07;
            else      c = c << 1;
         end
      end
      return c;
   endfunction

   // Scoreboard: every cfg_done must match the oldest outstanding expected select.
   always @(negedge clk) begin
      if (rst_n && cfg_done) begin
         doneCount++;
         if (expQ.size() == 0) begin
            checkOutput("unexpected_done", 64'(select), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            checkOutput("commit_select", 64'(select), 64'(expQ.pop_front()));
         end
      end
   end

   // Present one byte with valid high and return once it has been accepted.
   task automatic applyStimulus(input logic [7:0] d, output int waits);
      waits = 0;
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_data  = d;
      while (!cfg_ready && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      if (!cfg_ready) checkOutput("ready_timeout", 64'(cfg_ready), 64'd1);
      @(posedge clk);
   endtask

   task automatic sendFrame(input logic [39:0] f, input logic [35:0] expSel, output int firstWaits);
      int w;
      expQ.push_back(expSel);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(f[8*k +: 8], w);
         if (k == 0) firstWaits = w;
      end
`ifdef ROUTING_CFG_CRC_EN
      applyStimulus(refCrc(f), w);
`endif
   endtask

   // Called right after the final handshake edge: checks one-cycle latency and pulse width.
   task automatic endFrame(input logic [35:0] prevSel, input logic [35:0] newSel, input logic abortInCommit);
      @(negedge clk);
      cfg_valid = 1'b0;
      cfg_abort = abortInCommit;
      checkOutput("done_not_early", 64'(cfg_done), 64'd0);
      checkOutput("select_hold_until_commit", 64'(select), 64'(prevSel));
      checkOutput("ready_low_in_commit", 64'(cfg_ready), 64'd0);
      @(negedge clk);
      cfg_abort = 1'b0;
      checkOutput("done_pulse", 64'(cfg_done), 64'd1);
      checkOutput("err_quiet_on_commit", 64'(cfg_err), 64'd0);
      @(negedge clk);
      checkOutput("done_one_cycle", 64'(cfg_done), 64'd0);
      checkOutput("select_after_commit", 64'(select), 64'(newSel));
      checkOutput("ready_after_commit", 64'(cfg_ready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int w;
      int w2;
      int doneBefore;
      logic [35:0] prevSel;

      vecs[0] = '{frame: 40'hF544332211, expSel: 36'h544332211};
      vecs[1] = '{frame: 40'hFFFFFFFFFF, expSel: 36'hFFFFFFFFF};
      vecs[2] = '{frame: 40'h0000000000, expSel: 36'h000000000};
      vecs[3] = '{frame: 40'h0123456789, expSel: 36'h123456789};

      cfg_data  = 8'h00;
      cfg_valid = 1'b0;
      cfg_abort = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_select", 64'(select), 64'd0);
      checkOutput("reset_done", 64'(cfg_done), 64'd0);
      checkOutput("reset_err", 64'(cfg_err), 64'd0);
      checkOutput("reset_ready", 64'(cfg_ready), 64'd0);
      rst_n = 1'b1;
      #1;
      checkOutput("ready_after_reset", 64'(cfg_ready), 64'd1);
      prevSel = '0;

      for (int i = 0; i < 4; i++) begin
         sendFrame(vecs[i].frame, vecs[i].expSel, w);
         endFrame(prevSel, vecs[i].expSel, (i == 1));
         prevSel = vecs[i].expSel;
      end

      // Partial frame then abort: select must not move until a full new frame commits.
      for (int k = 0; k < 3; k++) applyStimulus(8'h55, w);
      @(negedge clk);
      cfg_valid = 1'b0;
      cfg_abort = 1'b1;
      @(negedge clk);
      cfg_abort = 1'b0;
      checkOutput("abort_select_hold", 64'(select), 64'(prevSel));
      checkOutput("abort_no_done", 64'(cfg_done), 64'd0);
      checkOutput("abort_no_err", 64'(cfg_err), 64'd0);
      sendFrame(40'hAAAAAAAAAA, 36'hAAAAAAAAA, w);
      endFrame(prevSel, 36'hAAAAAAAAA, 1'b0);
      prevSel = 36'hAAAAAAAAA;

      // Abort coincident with the second byte's handshake drops that byte.
      applyStimulus(8'h77, w);
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_data  = 8'h99;
      cfg_abort = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      cfg_abort = 1'b0;
      checkOutput("coincident_abort_hold", 64'(select), 64'(prevSel));
      sendFrame(40'h0504030201, 36'h504030201, w);
      endFrame(prevSel, 36'h504030201, 1'b0);
      prevSel = 36'h504030201;

      // Back-to-back frames with valid held high: single bubble between them.
      doneBefore = doneCount;
      sendFrame(40'h6655443322, 36'h655443322, w);
      sendFrame(40'h3C3C3C3C3C, 36'hC3C3C3C3C, w2);
      checkOutput("b2b_bubble_cycles", 64'(w2), 64'd1);
      endFrame(36'h655443322, 36'hC3C3C3C3C, 1'b0);
      checkOutput("b2b_done_pulses", 64'(doneCount - doneBefore), 64'd2);
      prevSel = 36'hC3C3C3C3C;

      // Reset between 4th and 5th bytes after a known commit.
      sendFrame(40'h0123456789, 36'h123456789, w);
      endFrame(prevSel, 36'h123456789, 1'b0);
      for (int k = 0; k < 4; k++) applyStimulus(8'h10 + 8'(k), w);
      @(negedge clk);
      cfg_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_reset_select", 64'(select), 64'd0);
      checkOutput("async_reset_ready", 64'(cfg_ready), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      sendFrame(40'hDEADBEEF42, 36'hEADBEEF42, w);
      endFrame(36'h0, 36'hEADBEEF42, 1'b0);
      prevSel = 36'hEADBEEF42;

`ifdef ROUTING_CFG_CRC_EN
      sendFrame(40'h0000000001, 36'h000000001, w);
      endFrame(prevSel, 36'h000000001, 1'b0);
      prevSel = 36'h000000001;
      for (int k = 0; k < 5; k++) applyStimulus((k == 0) ? 8'h02 : 8'h00, w);
      applyStimulus(refCrc(40'h0000000002) ^ 8'h10, w);
      @(negedge clk);
      cfg_valid = 1'b0;
      checkOutput("crc_err_pulse", 64'(cfg_err), 64'd1);
      checkOutput("crc_err_no_done", 64'(cfg_done), 64'd0);
      checkOutput("crc_err_select_hold", 64'(select), 64'(prevSel));
      @(negedge clk);
      checkOutput("crc_err_one_cycle", 64'(cfg_err), 64'd0);
      checkOutput("crc_err_ready_idle", 64'(cfg_ready), 64'd1);
      sendFrame(40'h0000000001, 36'h000000001, w);
      endFrame(prevSel, 36'h000000001, 1'b0);
`endif

      repeat (3) @(negedge clk);
      checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
